// File: rtl/load_data_aligner_pkg.sv
// Shared constants for the load aligner: datapath widths, load func3 codes, legality helpers.
// No logic of its own; imported by the aligner and its extend sub-block.
package load_data_aligner_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int FUNC3_WIDTH = 3;

    localparam logic [FUNC3_WIDTH-1:0] F3_LB  = 3'b000;
    localparam logic [FUNC3_WIDTH-1:0] F3_LH  = 3'b001;
    localparam logic [FUNC3_WIDTH-1:0] F3_LW  = 3'b010;
    localparam logic [FUNC3_WIDTH-1:0] F3_LBU = 3'b100;
    localparam logic [FUNC3_WIDTH-1:0] F3_LHU = 3'b101;

    function automatic logic f3_is_load(input logic [FUNC3_WIDTH-1:0] f3);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    // Halfwords must sit on even addresses, words on multiples of four.
    function automatic logic f3_misaligned(input logic [FUNC3_WIDTH-1:0] f3,
                                           input logic [1:0]             off);
        return (((f3 == F3_LH) || (f3 == F3_LHU)) && off[0]) ||
               ((f3 == F3_LW) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/load_data_extend.sv
// Selects the addressed byte/halfword/word from a BRAM word and sign/zero-extends it.
// Purely combinational (0 cycles); no flow control.
// Unknown func3 codes produce zero.
module load_data_extend
    import load_data_aligner_pkg::*;
(
    input  logic [DATA_WIDTH-1:0]  word,
    input  logic [1:0]             offset,
    input  logic [FUNC3_WIDTH-1:0] func3,
    output logic [DATA_WIDTH-1:0]  data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (offset)
            2'b00: byte_sel = word[7:0];
            2'b01: byte_sel = word[15:8];
            2'b10: byte_sel = word[23:16];
            2'b11: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel = offset[1] ? word[31:16] : word[15:0];

        data = '0;
        case (func3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  data = {24'h0, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  data = {16'h0, half_sel};
            F3_LW:   data = word;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/load_data_aligner.sv
// Load aligner: one word-aligned BRAM read per load, result extended for write-back.
// Latency: ld_done BRAM_LATENCY+2 cycles after acceptance; illegal/trapped loads 1 cycle.
// Backpressure: ld_busy stalls the core until ld_done; optional trap via LOAD_MISALIGN_TRAP_EN.
module load_data_aligner
    import load_data_aligner_pkg::*;
#(
    parameter int BRAM_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ld_req,
    input  logic [DATA_WIDTH-1:0]  ld_addr,
    input  logic [FUNC3_WIDTH-1:0] func3,
    output logic                   mem_rd_enb,
    output logic [DATA_WIDTH-1:0]  mem_addr,
    input  logic [DATA_WIDTH-1:0]  mem_rd_data,
    output logic                   ld_busy,
    output logic                   ld_done,
    output logic [DATA_WIDTH-1:0]  ld_data,
    output logic                   ld_misaligned
);

    localparam int CNT_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [1:0]             off_q;
    logic [FUNC3_WIDTH-1:0] f3_q;
    logic                   accept, capture, trap, bypass;
    logic [DATA_WIDTH-1:0]  ext_data;

`ifdef LOAD_MISALIGN_TRAP_EN
    logic mis_q;

    assign trap = f3_misaligned(func3, ld_addr[1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= accept && trap;
        end
    end

    assign ld_misaligned = mis_q;
`else
    assign trap          = 1'b0;
    assign ld_misaligned = 1'b0;
`endif

    // Requests that never touch memory go straight to DONE.
    assign bypass = !f3_is_load(func3) || trap;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ld_req) begin
                    accept    = 1'b1;
                    state_nxt = bypass ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                cnt_nxt   = CNT_W'(BRAM_LATENCY - 1);
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = ST_DONE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            mem_rd_enb <= 1'b0;
            mem_addr   <= '0;
            ld_done    <= 1'b0;
            ld_data    <= '0;
            off_q      <= '0;
            f3_q       <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            mem_rd_enb <= accept && !bypass;
            ld_done    <= (accept && bypass) || capture;
            if (accept) begin
                mem_addr <= {ld_addr[DATA_WIDTH-1:2], 2'b00};
                off_q    <= ld_addr[1:0];
                f3_q     <= func3;
                if (bypass) begin
                    ld_data <= '0;
                end
            end
            if (capture) begin
                ld_data <= ext_data;
            end
        end
    end

    assign ld_busy = ((state == ST_IDLE) && ld_req) || (state == ST_REQ) || (state == ST_WAIT);

    load_data_extend u_extend (
        .word   (mem_rd_data),
        .offset (off_q),
        .func3  (f3_q),
        .data   (ext_data)
    );

endmodule

// File: tb/tb_load_data_aligner.sv
// Bench for load_data_aligner: two instances (BRAM_LATENCY 1 and 3) share stimulus,
// each fed by its own behavioural BRAM; results compared against a reference model.
module tb_load_data_aligner;
    import load_data_aligner_pkg::*;

    localparam logic [31:0] POISON = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic [2:0]  func3;

    logic        enb   [2];
    logic [31:0] maddr [2];
    logic        busy  [2];
    logic        done  [2];
    logic [31:0] ldd   [2];
    logic        misf  [2];
    logic [31:0] rd1, rd3;
    logic [31:0] p3 [3];
    logic [31:0] mem [0:255];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_data_aligner #(.BRAM_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .ld_req(ld_req), .ld_addr(ld_addr), .func3(func3),
        .mem_rd_enb(enb[0]), .mem_addr(maddr[0]), .mem_rd_data(rd1),
        .ld_busy(busy[0]), .ld_done(done[0]), .ld_data(ldd[0]), .ld_misaligned(misf[0])
    );

    load_data_aligner #(.BRAM_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .ld_req(ld_req), .ld_addr(ld_addr), .func3(func3),
        .mem_rd_enb(enb[1]), .mem_addr(maddr[1]), .mem_rd_data(rd3),
        .ld_busy(busy[1]), .ld_done(done[1]), .ld_data(ldd[1]), .ld_misaligned(misf[1])
    );

    // BRAMs: read data appears exactly LATENCY cycles after the enable; otherwise poison.
    always @(posedge clk) begin
        rd1   <= enb[0] ? mem[maddr[0][9:2]] : POISON;
        p3[0] <= enb[1] ? mem[maddr[1][9:2]] : POISON;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign rd3 = p3[2];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // Reference: byte/half/word pick by shifting, extension by two's-complement arithmetic.
    function automatic void model(input logic [31:0] w, input logic [31:0] a, input logic [2:0] f3,
                                  output bit acc, output bit mis, output logic [31:0] res);
        int unsigned off;
        logic [31:0] v;
        off = 32'(a[1:0]);
        acc = 1'b1;
        mis = 1'b0;
        res = 32'h0;
        case (f3)
            3'b000, 3'b100: begin
                v = (w >> (8 * off)) & 32'hFF;
                if (f3 == 3'b000 && v >= 32'd128) v = v - 32'd256;
                res = v;
            end
            3'b001, 3'b101: begin
                v = (w >> (16 * (off / 2))) & 32'hFFFF;
                if (f3 == 3'b001 && v >= 32'd32768) v = v - 32'd65536;
                res = v;
`ifdef LOAD_MISALIGN_TRAP_EN
                if (off % 2 == 1) mis = 1'b1;
`endif
            end
            3'b010: begin
                res = w;
`ifdef LOAD_MISALIGN_TRAP_EN
                if (off != 0) mis = 1'b1;
`endif
            end
            default: acc = 1'b0;
        endcase
        if (mis) begin
            acc = 1'b0;
            res = 32'h0;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        for (int d = 0; d < 2; d++) begin
            check({tag, "_rd_enb"},     32'(enb[d]),  32'h0);
            check({tag, "_mem_addr"},   maddr[d],     32'h0);
            check({tag, "_busy"},       32'(busy[d]), 32'h0);
            check({tag, "_done"},       32'(done[d]), 32'h0);
            check({tag, "_ld_data"},    ldd[d],       32'h0);
            check({tag, "_misaligned"}, 32'(misf[d]), 32'h0);
        end
    endtask

    task automatic run_load(input logic [31:0] addr, input logic [2:0] f3);
        bit          acc, mis;
        logic [31:0] exp_data;
        int          done_cyc [2];
        int          enb_cnt  [2];
        int          busy_bad [2];
        logic [31:0] got_addr [2];
        logic [31:0] got_data [2];
        logic        got_mis  [2];
        logic        exp_busy;

        model(mem[addr[9:2]], addr, f3, acc, mis, exp_data);
        @(negedge clk);
        ld_req  = 1'b1;
        ld_addr = addr;
        func3   = f3;
        #1;
        for (int d = 0; d < 2; d++) begin
            check("busy_at_accept", 32'(busy[d]), 32'h1);
            done_cyc[d] = -1;
            enb_cnt[d]  = 0;
            busy_bad[d] = 0;
            got_addr[d] = 32'h0;
            got_data[d] = POISON;
            got_mis[d]  = 1'b0;
        end
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            ld_req = 1'b0;
            #1;
            for (int d = 0; d < 2; d++) begin
                exp_busy = acc && (c <= lat(d) + 1);
                if (busy[d] !== exp_busy) busy_bad[d]++;
                if (enb[d]) begin
                    enb_cnt[d] += (c == 1) ? 1 : 100;
                    got_addr[d] = maddr[d];
                end
                if (done[d]) begin
                    if (done_cyc[d] < 0) begin
                        done_cyc[d] = c;
                        got_data[d] = ldd[d];
                        got_mis[d]  = misf[d];
                    end else begin
                        done_cyc[d] += 100;
                    end
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            check("done_cycle", 32'(done_cyc[d]), acc ? 32'(lat(d) + 2) : 32'd1);
            check("rd_enb_pattern", 32'(enb_cnt[d]), acc ? 32'd1 : 32'd0);
            if (acc) check("mem_addr", got_addr[d], {addr[31:2], 2'b00});
            check("ld_data", got_data[d], exp_data);
            check("misaligned", 32'(got_mis[d]), 32'(mis));
            check("busy_pattern", 32'(busy_bad[d]), 32'h0);
            check("ld_data_hold", ldd[d], exp_data);
        end
    endtask

    task automatic run_reset(input int at_c);
        int spurious;
        spurious = 0;
        @(negedge clk);
        ld_req  = 1'b1;
        ld_addr = 32'h100;
        func3   = F3_LW;
        for (int c = 1; c <= at_c; c++) begin
            @(negedge clk);
            ld_req = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_idle("mid_rst");
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #1;
            for (int d = 0; d < 2; d++) if (done[d]) spurious++;
        end
        check("no_done_after_rst", 32'(spurious), 32'h0);
        run_load(32'h100, F3_LW);
    endtask

    initial begin
        logic [7:0] idx;
        logic [1:0] off;
        rst     = 1'b1;
        ld_req  = 1'b0;
        ld_addr = 32'h0;
        func3   = 3'b000;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[64] = 32'h8A7F_C301;

        repeat (3) @(negedge clk);
        #1;
        check_idle("reset");
        rst = 1'b0;

        run_load(32'h103, F3_LB);
        run_load(32'h101, F3_LBU);
        run_load(32'h102, F3_LH);
        run_load(32'h100, F3_LHU);
        run_load(32'h100, F3_LW);
        run_load(32'h102, F3_LW);
        run_load(32'h101, F3_LH);
        run_load(32'h103, F3_LHU);
        run_load(32'h100, 3'b011);
        run_load(32'h100, 3'b110);
        run_load(32'h100, 3'b111);
        run_load(32'h100, F3_LW);

        run_reset(1);
        run_reset(2);

        for (int n = 0; n < 40; n++) begin
            idx      = 8'($urandom_range(0, 255));
            off      = 2'($urandom_range(0, 3));
            mem[idx] = $urandom;
            run_load({22'h0, idx, off}, 3'($urandom_range(0, 7)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
